// File: rtl/word_scatter_16x32_pkg.sv
// Shared sizing and state encoding for the 16-lane word scatter bank.
package word_scatter_16x32_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    // Distinct-lane count at which one more new lane completes the bank
    localparam logic [SEL_W:0] LAST_COUNT = (SEL_W + 1)'(NUM_LANES - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/word_scatter_16x32_if.sv
// Upstream word stream and downstream bank handshake for the scatter block.
interface word_scatter_16x32_if;
    import word_scatter_16x32_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_data;
    logic                          in_auto;
    logic [SEL_W-1:0]              in_sel;
    logic                          in_last;
    logic [NUM_LANES*DATA_W-1:0]   lane_data;
    logic [NUM_LANES-1:0]          lane_written;
    logic [SEL_W:0]                lane_count;
    logic                          bank_valid;
    logic                          bank_ready;

    modport master (
        output in_valid, in_data, in_auto, in_sel, in_last, bank_ready,
        input  in_ready, lane_data, lane_written, lane_count, bank_valid
    );

    modport slave (
        input  in_valid, in_data, in_auto, in_sel, in_last, bank_ready,
        output in_ready, lane_data, lane_written, lane_count, bank_valid
    );

endinterface

// File: rtl/word_scatter_lane_reg.sv
// One lane of the bank: a word register with write enable and synchronous clear.
module word_scatter_lane_reg
    import word_scatter_16x32_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/word_scatter_16x32.sv
// Scatters a stream of words into 16 registered lanes and hands the bank off whole.
module word_scatter_16x32
    import word_scatter_16x32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    word_scatter_16x32_if.slave  bus
);

    state_t                      state_reg, state_next;
    logic [SEL_W-1:0]            wr_ptr_reg, wr_ptr_next;
    logic [NUM_LANES-1:0]        written_reg, written_next;
    logic [SEL_W:0]              count_reg, count_next;
    logic [NUM_LANES-1:0]        lane_we;
    logic [SEL_W-1:0]            target;
    logic                        new_lane;
    logic [NUM_LANES*DATA_W-1:0] lane_data_flat;

    assign target   = bus.in_auto ? wr_ptr_reg : bus.in_sel;
    assign new_lane = ~written_reg[target];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FILL;
            wr_ptr_reg  <= '0;
            written_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            written_reg <= written_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        written_next = written_reg;
        count_next   = count_reg;
        lane_we      = '0;
        case (state_reg)
            ST_FILL: begin
                if (bus.in_valid) begin
                    lane_we[target]      = 1'b1;
                    written_next[target] = 1'b1;
                    if (new_lane) begin
                        count_next = count_reg + 1'b1;
                    end
                    if (bus.in_auto) begin
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                    end
                    // A rewrite with in_last still closes the bank
                    if (bus.in_last || (new_lane && count_reg == LAST_COUNT)) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.bank_ready) begin
                    state_next   = ST_FILL;
                    wr_ptr_next  = '0;
                    written_next = '0;
                    count_next   = '0;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Lane contents survive a release; only reset clears them
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            word_scatter_lane_reg #(.W(DATA_W)) u_lane (
                .clk (clk),
                .rst (rst),
                .we  (lane_we[gi]),
                .d   (bus.in_data),
                .q   (lane_data_flat[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign bus.in_ready     = (state_reg == ST_FILL);
    assign bus.bank_valid   = (state_reg == ST_HOLD);
    assign bus.lane_data    = lane_data_flat;
    assign bus.lane_written = written_reg;
    assign bus.lane_count   = count_reg;

endmodule
